alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised successor to the 8-bit bus ALU of the breadboard CPU datapath.
- Holds operand registers A and B loaded from the shared bus, and drives result, A, B or the product high half back onto the bus.
- Adds an opcode-selected operation set, a status-flags register, multi-cycle shifts and a sequential shift-add multiplier, with a start/busy/done handshake to the controller.

Parameters:
- WIDTH, 8, datapath width in bits (must be >= 4).
- SHW, $clog2(WIDTH), shift-amount width (localparam, derived, not overridable).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- op  input  4  operation code, sampled with start.
- start  input  1  begin operation; accepted only in IDLE.
- rega_write_enable  input  1  load A from bus_in.
- regb_write_enable  input  1  load B from bus_in.
- alu_enable  input  1  drive result onto bus_out.
- rega_enable  input  1  drive A onto bus_out.
- regb_enable  input  1  drive B onto bus_out.
- hi_enable  input  1  drive product high half onto bus_out.
- bus_in  input  WIDTH  bus data.
- bus_out  output  WIDTH  bus data; all-ones when not driving.
- busy  output  1  multi-cycle operation in progress.
- done  output  1  one-cycle pulse when result and flags update.
- flags  output  4  {C,Z,N,V}.
- carry_out  output  1  equals flags[3].

Behaviour:
- Reset (rst=0, asynchronous):
  - A, B, result, hi and flags clear to 0.
  - State goes to IDLE; busy=0, done=0.
  - Reset mid-operation aborts the operation with no result or flag update.
- bus_out is combinational, priority alu_enable > rega_enable > regb_enable > hi_enable, else {WIDTH{1'b1}}.
  - It always shows the committed result and hi registers, never intermediate values.
- Register loads:
  - rega_write_enable has priority over regb_write_enable.
  - Loads are ignored while busy=1.
  - A load on the same edge as start affects only later operations; the operation uses the pre-edge A and B.
- States: IDLE, SHIFT, MUL.
  - start is sampled at edge k in IDLE. Operands and op are snapshotted into working registers.
  - start while busy is ignored.
- Single-cycle ops commit result/flags at edge k; done=1 for the following cycle; busy stays 0.
  - 0 ADD: A+B.
  - 1 SUB: A+~B+1.
  - 2 ADC: A+B+C.
  - 3 SBB: A+~B+C.
  - 4 AND, 5 OR, 6 XOR, 7 NOT: ~A.
  - 13 INC: A+1.
  - 14 DEC: A+~0.
  - Arithmetic is WIDTH+1 bits. C = bit WIDTH, so for subtraction C=1 means no borrow. V = signed overflow.
  - Logic ops force C=0, V=0.
- Shifts use amount n = B[SHW-1:0]:
  - 8 SHL, 9 SHR (logical), 10 ASR, 11 ROL.
  - n=0: commit at edge k as a single-cycle op, result=A, C=0.
  - n>0: enter SHIFT with busy=1. Shift one bit per edge; commit at edge k+n, then busy=0, done=1.
  - C = last bit shifted out (for ROL, the bit rotated). V=0.
- 12 MUL (unsigned shift-add):
  - Enter MUL with busy=1; one multiplier bit per edge; commit at edge k+WIDTH.
  - result = product low half; hi = product high half.
  - C = V = (hi != 0). Z over the full 2*WIDTH product. N = product msb.
- Z = (result == 0) and N = result msb, except MUL as above.
- Ops 15 and unused codes: done pulses at edge k; result, hi and flags are unchanged.
- hi changes only on MUL commit.
- start in the cycle where done=1 is legal (state is already IDLE) and is accepted.

Decomposition:
- Package alu_seq_pkg: opcode constants OP_ADD..OP_DEC, flag bit indices FLAG_C/Z/N/V, state encoding.
- Sub-module alu_seq_addsub: combinational WIDTH-bit ripple adder, inputs a, b, cin, invert_b; outputs sum, cout, ovf. Shared by all arithmetic ops and by the MUL accumulate step.

Test Plan:
- WIDTH=8, A=0xFF, B=0x01, ADD -> edge after start: result 0x00, flags C=1 Z=1 N=0 V=0, done for 1 cycle, busy never high.
- SUB with A=0x05, B=0x07 -> 0xFE, C=0 Z=0 N=1 V=0. Then A=0x80, B=0x01, SUB -> 0x7F, C=1 V=1. Then ADC with C=1, A=0x01, B=0x01 -> 0x03.
- SHL with A=0x81, B=0x03 -> busy for 3 cycles, commit at edge k+3: result 0x08, C=0. A bus write during busy leaves A=0x81. A start during busy is ignored.
- MUL with A=0x10, B=0x20 -> done at edge k+8: result 0x00, hi 0x02, C=V=1, Z=0; hi_enable shows 0x02 on bus_out. MUL 0x00*0x55 -> Z=1, C=0.
- rst pulled low at cycle 3 of MUL -> immediately busy=0, done=0, flags=0, A=B=0, bus_out=0xFF with no enables. The next ADD after release behaves normally.
- Back-to-back: start ADD held high across the done cycle -> second ADD accepted, done high 2 consecutive cycles; bus priority check with all enables high -> result shown.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// ============================================================================
// alu_seq_pkg : opcodes, flag bit positions and FSM encoding for alu_seq
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_ADC = 4'd2;
   localparam logic [3:0] OP_SBB = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8;
   localparam logic [3:0] OP_SHR = 4'd9;
   localparam logic [3:0] OP_ASR = 4'd10;
   localparam logic [3:0] OP_ROL = 4'd11;
   localparam logic [3:0] OP_MUL = 4'd12;
   localparam logic [3:0] OP_INC = 4'd13;
   localparam logic [3:0] OP_DEC = 4'd14;

   // flags vector is {C,Z,N,V}
   localparam int FLAG_C = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_MUL   = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_seq_if.sv
// ============================================================================
// alu_seq_if : controller <-> ALU bus and handshake bundle
// Revision   : 1.0
// ============================================================================
`default_nettype none

interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic [3:0]       op;
   logic             start;
   logic             rega_write_enable;
   logic             regb_write_enable;
   logic             alu_enable;
   logic             rega_enable;
   logic             regb_enable;
   logic             hi_enable;
   logic [WIDTH-1:0] bus_in;
   logic [WIDTH-1:0] bus_out;
   logic             busy;
   logic             done;
   logic [3:0]       flags;
   logic             carry_out;

   modport master (
      output op, start, rega_write_enable, regb_write_enable,
             alu_enable, rega_enable, regb_enable, hi_enable, bus_in,
      input  bus_out, busy, done, flags, carry_out
   );

   modport slave (
      input  op, start, rega_write_enable, regb_write_enable,
             alu_enable, rega_enable, regb_enable, hi_enable, bus_in,
      output bus_out, busy, done, flags, carry_out
   );
endinterface

`default_nettype wire

// File: rtl/alu_seq_addsub.sv
// ============================================================================
// alu_seq_addsub : combinational ripple adder with optional b inversion
// Revision       : 1.0
// ============================================================================
`default_nettype none

module alu_seq_addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             invert_b,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH-1:0] bb;

   always_comb begin
      logic c;
      bb  = invert_b ? ~b : b;
      sum = '0;
      c   = cin;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = a[i] ^ bb[i] ^ c;
         c      = (a[i] & bb[i]) | (c & (a[i] ^ bb[i]));
      end
      cout = c;
      // overflow: both addends share a sign that the sum does not
      ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq : bus ALU with flags, multi-cycle shifts and shift-add multiplier
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic      clk,
   input  logic      rst,
   alu_seq_if.slave  bus
);

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = SHW + 1;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_q, b_q, res_q, hi_q;
   logic [3:0]       flags_q;
   logic             done_q;

   logic [3:0]       wop_q, wop_nx;
   logic [WIDTH-1:0] wval_q, wval_nx, wmc_q, wmc_nx, wacc_q, wacc_nx;
   logic [CW-1:0]    cnt_q, cnt_nx;

   logic             commit, hi_wr, done_nx;
   logic [WIDTH-1:0] res_nx, hi_nx;
   logic [3:0]       flags_nx;

   logic [WIDTH-1:0] add_a, add_b, add_sum;
   logic             add_cin, add_inv, add_cout, add_ovf;
   logic [WIDTH:0]   sh_step, mul_ext;
   logic [2*WIDTH-1:0] prod;
   logic [SHW-1:0]   amt;

   assign amt = b_q[SHW-1:0];

   // one-bit shift step, returns {bit_out, shifted_value}
   function automatic logic [WIDTH:0] shift1(input logic [3:0] sop, input logic [WIDTH-1:0] v);
      case (sop)
         OP_SHL:  return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
         OP_SHR:  return {v[0], 1'b0, v[WIDTH-1:1]};
         OP_ASR:  return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
         default: return {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      endcase
   endfunction

   alu_seq_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a        (add_a),
      .b        (add_b),
      .cin      (add_cin),
      .invert_b (add_inv),
      .sum      (add_sum),
      .cout     (add_cout),
      .ovf      (add_ovf)
   );

   always_comb begin
      add_a   = a_q;
      add_b   = b_q;
      add_cin = 1'b0;
      add_inv = 1'b0;
      if (state == ST_MUL) begin
         add_a = wacc_q;
         add_b = wmc_q;
      end else begin
         case (bus.op)
            OP_SUB:  begin add_inv = 1'b1; add_cin = 1'b1; end
            OP_ADC:  add_cin = flags_q[FLAG_C];
            OP_SBB:  begin add_inv = 1'b1; add_cin = flags_q[FLAG_C]; end
            OP_INC:  begin add_b = '0; add_cin = 1'b1; end
            OP_DEC:  begin add_b = '0; add_inv = 1'b1; end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      wop_nx   = wop_q;
      wval_nx  = wval_q;
      wmc_nx   = wmc_q;
      wacc_nx  = wacc_q;
      cnt_nx   = cnt_q;
      commit   = 1'b0;
      hi_wr    = 1'b0;
      done_nx  = 1'b0;
      res_nx   = res_q;
      hi_nx    = hi_q;
      flags_nx = flags_q;
      prod     = '0;
      sh_step  = shift1(wop_q, wval_q);
      mul_ext  = wval_q[0] ? {add_cout, add_sum} : {1'b0, wacc_q};

      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               case (bus.op)
                  OP_ADD, OP_SUB, OP_ADC, OP_SBB, OP_INC, OP_DEC: begin
                     commit           = 1'b1;
                     res_nx           = add_sum;
                     flags_nx[FLAG_C] = add_cout;
                     flags_nx[FLAG_V] = add_ovf;
                  end
                  OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                     commit           = 1'b1;
                     flags_nx[FLAG_C] = 1'b0;
                     flags_nx[FLAG_V] = 1'b0;
                     case (bus.op)
                        OP_AND:  res_nx = a_q & b_q;
                        OP_OR:   res_nx = a_q | b_q;
                        OP_XOR:  res_nx = a_q ^ b_q;
                        default: res_nx = ~a_q;
                     endcase
                  end
                  OP_SHL, OP_SHR, OP_ASR, OP_ROL: begin
                     if (amt == '0) begin
                        commit           = 1'b1;
                        res_nx           = a_q;
                        flags_nx[FLAG_C] = 1'b0;
                        flags_nx[FLAG_V] = 1'b0;
                     end else begin
                        state_nx = ST_SHIFT;
                        wop_nx   = bus.op;
                        wval_nx  = a_q;
                        cnt_nx   = {1'b0, amt};
                     end
                  end
                  OP_MUL: begin
                     state_nx = ST_MUL;
                     wacc_nx  = '0;
                     wval_nx  = b_q;
                     wmc_nx   = a_q;
                     cnt_nx   = CW'(WIDTH);
                  end
                  default: ;
               endcase
               done_nx = (state_nx == ST_IDLE);
            end
         end
         ST_SHIFT: begin
            wval_nx = sh_step[WIDTH-1:0];
            cnt_nx  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_nx         = ST_IDLE;
               commit           = 1'b1;
               done_nx          = 1'b1;
               res_nx           = sh_step[WIDTH-1:0];
               flags_nx[FLAG_C] = sh_step[WIDTH];
               flags_nx[FLAG_V] = 1'b0;
            end
         end
         ST_MUL: begin
            // accumulate-then-shift: {acc,multiplier} becomes the product after WIDTH steps
            {wacc_nx, wval_nx} = {mul_ext, wval_q[WIDTH-1:1]};
            cnt_nx             = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               prod             = {wacc_nx, wval_nx};
               state_nx         = ST_IDLE;
               commit           = 1'b1;
               hi_wr            = 1'b1;
               done_nx          = 1'b1;
               res_nx           = wval_nx;
               hi_nx            = wacc_nx;
               flags_nx[FLAG_C] = (wacc_nx != '0);
               flags_nx[FLAG_V] = (wacc_nx != '0);
               flags_nx[FLAG_Z] = (prod == '0);
               flags_nx[FLAG_N] = prod[2*WIDTH-1];
            end
         end
         default: state_nx = ST_IDLE;
      endcase

      if (commit && !hi_wr) begin
         flags_nx[FLAG_Z] = (res_nx == '0);
         flags_nx[FLAG_N] = res_nx[WIDTH-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         hi_q    <= '0;
         flags_q <= '0;
         done_q  <= 1'b0;
         wop_q   <= '0;
         wval_q  <= '0;
         wmc_q   <= '0;
         wacc_q  <= '0;
         cnt_q   <= '0;
      end else begin
         done_q <= done_nx;
         wop_q  <= wop_nx;
         wval_q <= wval_nx;
         wmc_q  <= wmc_nx;
         wacc_q <= wacc_nx;
         cnt_q  <= cnt_nx;
         if (commit) begin
            res_q   <= res_nx;
            flags_q <= flags_nx;
         end
         if (hi_wr) hi_q <= hi_nx;
         if (state == ST_IDLE) begin
            if (bus.rega_write_enable)      a_q <= bus.bus_in;
            else if (bus.regb_write_enable) b_q <= bus.bus_in;
         end
      end
   end

   always_comb begin
      if (bus.alu_enable)       bus.bus_out = res_q;
      else if (bus.rega_enable) bus.bus_out = a_q;
      else if (bus.regb_enable) bus.bus_out = b_q;
      else if (bus.hi_enable)   bus.bus_out = hi_q;
      else                      bus.bus_out = {WIDTH{1'b1}};
   end

   assign bus.busy      = (state != ST_IDLE);
   assign bus.done      = done_q;
   assign bus.flags     = flags_q;
   assign bus.carry_out = flags_q[FLAG_C];

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// tb_alu_seq : directed self-checking bench for alu_seq (WIDTH=8)
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq;
   import alu_seq_pkg::*;

   localparam int W = 8;
   localparam logic [3:0] EN_NONE = 4'b0000;
   localparam logic [3:0] EN_ALU  = 4'b1000;
   localparam logic [3:0] EN_A    = 4'b0100;
   localparam logic [3:0] EN_B    = 4'b0010;
   localparam logic [3:0] EN_HI   = 4'b0001;

   // op, A, B, result, flags {C,Z,N,V}, cycles from start edge to commit
   localparam int NV = 13;
   localparam logic [3:0]   V_OP  [NV] = '{OP_SUB, OP_SUB, OP_ADC, OP_SBB, OP_INC, OP_DEC, OP_AND,
                                           OP_OR, OP_XOR, OP_NOT, OP_SHR, OP_ROL, OP_ASR};
   localparam logic [W-1:0] V_A   [NV] = '{8'h05, 8'h80, 8'h01, 8'h05, 8'h7F, 8'h00, 8'hF0,
                                           8'h00, 8'hF0, 8'h0F, 8'h81, 8'h81, 8'h81};
   localparam logic [W-1:0] V_B   [NV] = '{8'h07, 8'h01, 8'h01, 8'h03, 8'h00, 8'h00, 8'h3C,
                                           8'h00, 8'hFF, 8'h00, 8'h08, 8'h01, 8'h02};
   localparam logic [W-1:0] V_RES [NV] = '{8'hFE, 8'h7F, 8'h03, 8'h01, 8'h80, 8'hFF, 8'h30,
                                           8'h00, 8'h0F, 8'hF0, 8'h81, 8'h03, 8'hE0};
   localparam logic [3:0]   V_FLG [NV] = '{4'b0010, 4'b1001, 4'b0000, 4'b1000, 4'b0011, 4'b0010, 4'b0000,
                                           4'b0100, 4'b0000, 4'b0010, 4'b0010, 4'b1000, 4'b0010};
   localparam int           V_CYC [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2};

   logic clk;
   logic rst;
   int   passed = 0;
   int   total  = 0;

   alu_seq_if #(.WIDTH(W)) bus();

   alu_seq #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.op = 4'd0; bus.start = 1'b0;
      bus.rega_write_enable = 1'b0; bus.regb_write_enable = 1'b0;
      bus.alu_enable = 1'b0; bus.rega_enable = 1'b0;
      bus.regb_enable = 1'b0; bus.hi_enable = 1'b0;
      bus.bus_in = '0;
   endtask

   task automatic read_bus(input logic [3:0] en, output logic [W-1:0] v);
      {bus.alu_enable, bus.rega_enable, bus.regb_enable, bus.hi_enable} = en;
      #1;
      v = bus.bus_out;
      {bus.alu_enable, bus.rega_enable, bus.regb_enable, bus.hi_enable} = EN_NONE;
   endtask

   task automatic load(input logic sel_b, input logic [W-1:0] v);
      if (sel_b) bus.regb_write_enable = 1'b1;
      else       bus.rega_write_enable = 1'b1;
      bus.bus_in = v;
      tick();
      bus.rega_write_enable = 1'b0;
      bus.regb_write_enable = 1'b0;
   endtask

   // start op at edge k; cyc = edges after k until done is seen (bounded)
   task automatic run_op(input logic [3:0] o, output int cyc);
      bus.op = o; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset;
      logic [W-1:0] v;
      rst = 1'b0;
      idle_inputs();
      tick(); tick();
      total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
      total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else passed++;
      total++; if (bus.flags !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", bus.flags); else passed++;
      read_bus(EN_NONE, v);
      total++; if (v !== 8'hFF) $display("FAIL reset_bus_idle: got %h want ff", v); else passed++;
      read_bus(EN_ALU, v);
      total++; if (v !== 8'h00) $display("FAIL reset_result: got %h want 00", v); else passed++;
      read_bus(EN_A, v);
      total++; if (v !== 8'h00) $display("FAIL reset_a: got %h want 00", v); else passed++;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_add;
      logic [W-1:0] v;
      load(1'b0, 8'hFF);
      load(1'b1, 8'h01);
      bus.op = OP_ADD; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      total++; if (bus.done !== 1'b1) $display("FAIL add_done: got %b want 1", bus.done); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL add_busy: got %b want 0", bus.busy); else passed++;
      total++; if (bus.flags !== 4'b1100) $display("FAIL add_flags: got %b want 1100", bus.flags); else passed++;
      total++; if (bus.carry_out !== 1'b1) $display("FAIL add_carry_out: got %b want 1", bus.carry_out); else passed++;
      read_bus(EN_ALU, v);
      total++; if (v !== 8'h00) $display("FAIL add_result: got %h want 00", v); else passed++;
      tick();
      total++; if (bus.done !== 1'b0) $display("FAIL add_done_pulse: got %b want 0", bus.done); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL add_busy_after: got %b want 0", bus.busy); else passed++;
   endtask

   task automatic test_vectors;
      logic [W-1:0] v;
      int cyc;
      for (int i = 0; i < NV; i++) begin
         load(1'b0, V_A[i]);
         load(1'b1, V_B[i]);
         run_op(V_OP[i], cyc);
         total++; if (cyc != V_CYC[i]) $display("FAIL vec%0d_cycles: got %0d want %0d", i, cyc, V_CYC[i]); else passed++;
         total++; if (bus.flags !== V_FLG[i]) $display("FAIL vec%0d_flags: got %b want %b", i, bus.flags, V_FLG[i]); else passed++;
         read_bus(EN_ALU, v);
         total++; if (v !== V_RES[i]) $display("FAIL vec%0d_result: got %h want %h", i, v, V_RES[i]); else passed++;
         tick();
      end
   endtask

   task automatic test_shift_busy;
      logic [W-1:0] v;
      load(1'b0, 8'h81);
      load(1'b1, 8'h03);
      bus.op = OP_SHL; bus.start = 1'b1;
      tick();
      total++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) $display("FAIL shl_enter: got busy=%b done=%b want busy=1 done=0", bus.busy, bus.done); else passed++;
      // attempt a restart and an A write throughout the busy window
      bus.op = OP_ADD; bus.rega_write_enable = 1'b1; bus.bus_in = 8'h55;
      tick();
      total++; if (bus.busy !== 1'b1) $display("FAIL shl_busy1: got %b want 1", bus.busy); else passed++;
      tick();
      total++; if (bus.busy !== 1'b1) $display("FAIL shl_busy2: got %b want 1", bus.busy); else passed++;
      tick();
      bus.start = 1'b0; bus.rega_write_enable = 1'b0;
      total++; if (bus.busy !== 1'b0 || bus.done !== 1'b1) $display("FAIL shl_commit: got busy=%b done=%b want busy=0 done=1", bus.busy, bus.done); else passed++;
      total++; if (bus.flags !== 4'b0000) $display("FAIL shl_flags: got %b want 0000", bus.flags); else passed++;
      read_bus(EN_ALU, v);
      total++; if (v !== 8'h08) $display("FAIL shl_result: got %h want 08", v); else passed++;
      read_bus(EN_A, v);
      total++; if (v !== 8'h81) $display("FAIL shl_a_kept: got %h want 81", v); else passed++;
      tick();
      total++; if (bus.done !== 1'b0) $display("FAIL shl_no_restart: got done=%b want 0", bus.done); else passed++;
   endtask

   task automatic test_mul;
      logic [W-1:0] v;
      int cyc;
      load(1'b0, 8'h10);
      load(1'b1, 8'h20);
      run_op(OP_MUL, cyc);
      total++; if (cyc != 8) $display("FAIL mul1_cycles: got %0d want 8", cyc); else passed++;
      total++; if (bus.flags !== 4'b1001) $display("FAIL mul1_flags: got %b want 1001", bus.flags); else passed++;
      read_bus(EN_ALU, v);
      total++; if (v !== 8'h00) $display("FAIL mul1_lo: got %h want 00", v); else passed++;
      read_bus(EN_HI, v);
      total++; if (v !== 8'h02) $display("FAIL mul1_hi: got %h want 02", v); else passed++;
      tick();
      load(1'b0, 8'h00);
      load(1'b1, 8'h55);
      run_op(OP_MUL, cyc);
      total++; if (bus.flags !== 4'b0100) $display("FAIL mul0_flags: got %b want 0100", bus.flags); else passed++;
      read_bus(EN_HI, v);
      total++; if (v !== 8'h00) $display("FAIL mul0_hi: got %h want 00", v); else passed++;
      tick();
      load(1'b0, 8'hFF);
      load(1'b1, 8'hFF);
      run_op(OP_MUL, cyc);
      total++; if (bus.flags !== 4'b1011) $display("FAIL mulff_flags: got %b want 1011", bus.flags); else passed++;
      read_bus(EN_ALU, v);
      total++; if (v !== 8'h01) $display("FAIL mulff_lo: got %h want 01", v); else passed++;
      read_bus(EN_HI, v);
      total++; if (v !== 8'hFE) $display("FAIL mulff_hi: got %h want fe", v); else passed++;
      tick();
      // reserved opcode: done pulse only
      run_op(4'd15, cyc);
      total++; if (cyc != 0) $display("FAIL op15_cycles: got %0d want 0", cyc); else passed++;
      total++; if (bus.flags !== 4'b1011) $display("FAIL op15_flags: got %b want 1011", bus.flags); else passed++;
      read_bus(EN_ALU, v);
      total++; if (v !== 8'h01) $display("FAIL op15_result: got %h want 01", v); else passed++;
      read_bus(EN_HI, v);
      total++; if (v !== 8'hFE) $display("FAIL op15_hi: got %h want fe", v); else passed++;
      tick();
   endtask

   task automatic test_reset_mid_mul;
      logic [W-1:0] v;
      int cyc;
      load(1'b0, 8'h10);
      load(1'b1, 8'h20);
      bus.op = OP_MUL; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick(); tick();
      total++; if (bus.busy !== 1'b1) $display("FAIL rmid_busy_before: got %b want 1", bus.busy); else passed++;
      rst = 1'b0;
      #1;
      total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL rmid_state: got busy=%b done=%b want 0 0", bus.busy, bus.done); else passed++;
      total++; if (bus.flags !== 4'b0000) $display("FAIL rmid_flags: got %b want 0000", bus.flags); else passed++;
      read_bus(EN_NONE, v);
      total++; if (v !== 8'hFF) $display("FAIL rmid_bus_idle: got %h want ff", v); else passed++;
      read_bus(EN_A, v);
      total++; if (v !== 8'h00) $display("FAIL rmid_a: got %h want 00", v); else passed++;
      read_bus(EN_B, v);
      total++; if (v !== 8'h00) $display("FAIL rmid_b: got %h want 00", v); else passed++;
      read_bus(EN_HI, v);
      total++; if (v !== 8'h00) $display("FAIL rmid_hi: got %h want 00", v); else passed++;
      tick();
      rst = 1'b1;
      tick();
      load(1'b0, 8'h02);
      load(1'b1, 8'h03);
      run_op(OP_ADD, cyc);
      total++; if (cyc != 0) $display("FAIL rmid_add_cycles: got %0d want 0", cyc); else passed++;
      total++; if (bus.flags !== 4'b0000) $display("FAIL rmid_add_flags: got %b want 0000", bus.flags); else passed++;
      read_bus(EN_ALU, v);
      total++; if (v !== 8'h05) $display("FAIL rmid_add_result: got %h want 05", v); else passed++;
      tick();
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] v;
      load(1'b0, 8'h01);
      load(1'b1, 8'h01);
      // A load on the start edge must only affect the second ADD
      bus.op = OP_ADD; bus.start = 1'b1;
      bus.rega_write_enable = 1'b1; bus.bus_in = 8'h05;
      tick();
      bus.rega_write_enable = 1'b0;
      total++; if (bus.done !== 1'b1) $display("FAIL b2b_done1: got %b want 1", bus.done); else passed++;
      read_bus(EN_ALU, v);
      total++; if (v !== 8'h02) $display("FAIL b2b_result1: got %h want 02", v); else passed++;
      tick();
      bus.start = 1'b0;
      total++; if (bus.done !== 1'b1) $display("FAIL b2b_done2: got %b want 1", bus.done); else passed++;
      read_bus(EN_ALU, v);
      total++; if (v !== 8'h06) $display("FAIL b2b_result2: got %h want 06", v); else passed++;
      tick();
      total++; if (bus.done !== 1'b0) $display("FAIL b2b_done3: got %b want 0", bus.done); else passed++;
      read_bus(EN_ALU | EN_A | EN_B | EN_HI, v);
      total++; if (v !== 8'h06) $display("FAIL prio_all: got %h want 06", v); else passed++;
      read_bus(EN_A | EN_B | EN_HI, v);
      total++; if (v !== 8'h05) $display("FAIL prio_a: got %h want 05", v); else passed++;
      read_bus(EN_B | EN_HI, v);
      total++; if (v !== 8'h01) $display("FAIL prio_b: got %h want 01", v); else passed++;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b0;
      test_reset();
      test_add();
      test_vectors();
      test_shift_busy();
      test_mul();
      test_reset_mid_mul();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
